cmd_frame_rcvr: RTL and testbench

//  Copter-side receiver for the wireless command link: deserialises 8N1 UART bytes on RX and assembles
//  3-byte frames {cmd, data[15:8], data[7:0]} into cmd/data with a cmd_rdy flag for the command-config FSM.

---
 rtl/quad_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 106 ++++++++++
 rtl/cmd_frame_rcvr.sv | 133 +++++++++++++
 tb/tb_cmd_frame_rcvr.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types for the command link: byte-level UART receive states and
// frame-level states (the frame type is reused by the response transmitter).
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } byte_state_e;

  typedef enum logic [1:0] {
    CMD = 2'd0,
    DHI = 2'd1,
    DLO = 2'd2
  } frame_state_e;

  localparam int FRAME_BYTES = 3;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop RX synchroniser, falling-edge start
// detect, half-bit start validation, LSB-first data sampling, stop check.
// Handshake: byte_vld_o is a 1-clk pulse with byte_o valid in the same clk;
// there is no back-pressure, the consumer must take it in that clk.
module uart_rx_byte
  import quad_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic [7:0]  byte_o,
  output logic        byte_vld_o,
  output logic        frm_err_o,
  output logic        rx_fall_o,
  output byte_state_e state_o
);

  if (BAUD_DIV < 16 || BAUD_DIV > 65535) begin : g_bad_baud
    $error("BAUD_DIV out of range 16..65535");
  end

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  byte_state_e state_q, state_d;
  logic [15:0] timer_q;
  logic [3:0]  idx_q;
  logic [7:0]  shift_q;
  logic        rx_fall;
  logic        tick;

  assign rx_fall   = rx_prev_q & ~rx_s2_q;
  assign rx_fall_o = rx_fall;
  assign byte_o    = shift_q;
  assign state_o   = state_q;

  // Synchroniser and edge-detect flops, preset high so reset release is not a start bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Sample strobe: half a bit in START, a full bit in DATA and STOP
  always_comb begin
    tick = 1'b0;
    case (state_q)
      START:       tick = (timer_q == HALF_LAST);
      DATA, STOP:  tick = (timer_q == BIT_LAST);
      default:     tick = 1'b0;
    endcase
  end

  // Byte FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Byte FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_fall) state_d = START;
      START:   if (tick) state_d = rx_s2_q ? IDLE : DATA;
      DATA:    if (tick && idx_q == 4'd7) state_d = STOP;
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte FSM outputs: stop-bit verdict pulses
  always_comb begin
    byte_vld_o = 1'b0;
    frm_err_o  = 1'b0;
    if (state_q == STOP && tick) begin
      byte_vld_o = rx_s2_q;
      frm_err_o  = ~rx_s2_q;
    end
  end

  // Bit timer, bit index and shift register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= 16'd0;
      idx_q   <= 4'd0;
      shift_q <= 8'h00;
    end else begin
      if (state_q == IDLE || tick) timer_q <= 16'd0;
      else                         timer_q <= timer_q + 16'd1;
      if (state_q == START)             idx_q <= 4'd0;
      else if (state_q == DATA && tick) idx_q <= idx_q + 4'd1;
      if (state_q == DATA && tick) shift_q <= {rx_s2_q, shift_q[7:1]};
    end
  end

endmodule

// File: rtl/cmd_frame_rcvr.sv
// Command frame receiver: assembles {cmd, data_hi, data_lo} from UART bytes
// and presents cmd/data with a cmd_rdy level flag.
// Optional build macro FRAME_TIMEOUT_EN: drops a partial frame after
// TIMEOUT_CLKS idle clocks between bytes.
module cmd_frame_rcvr
  import quad_pkg::*;
#(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_CLKS = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        frm_err,
  output logic        ovr_err
);

  if (TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 131071 || FRAME_BYTES != 3) begin : g_bad_cfg
    $error("TIMEOUT_CLKS out of 17-bit range or unexpected frame length");
  end

  logic [7:0]   rx_byte;
  logic         byte_vld;
  logic         rx_fall;
  byte_state_e  byte_st;
  frame_state_e fst_q, fst_d;
  logic         timeout;
  logic         cap_cmd, cap_hi, complete;
  logic [7:0]   cmd_sh_q, dhi_sh_q;
  logic [7:0]   cmd_q, cmd_d;
  logic [15:0]  data_q, data_d;
  logic         rdy_q, rdy_d;
  logic         ovr_q, ovr_d;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (RX),
    .byte_o     (rx_byte),
    .byte_vld_o (byte_vld),
    .frm_err_o  (frm_err),
    .rx_fall_o  (rx_fall),
    .state_o    (byte_st)
  );

`ifdef FRAME_TIMEOUT_EN
  logic [16:0] gap_q;

  // Inter-byte gap counter: runs mid-frame while the line is idle
  always_ff @(posedge clk) begin
    if (rst || fst_q == CMD || rx_fall) gap_q <= 17'd0;
    else if (byte_st == IDLE)           gap_q <= gap_q + 17'd1;
  end

  assign timeout = (gap_q == 17'(TIMEOUT_CLKS));
`else
  logic unused_dbg;
  assign unused_dbg = rx_fall ^ (byte_st == IDLE);
  assign timeout    = 1'b0;
`endif

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (rst) fst_q <= CMD;
    else     fst_q <= fst_d;
  end

  // Frame FSM next state: errors and timeouts restart the frame
  always_comb begin
    fst_d = fst_q;
    if (frm_err || timeout) fst_d = CMD;
    else if (byte_vld) begin
      case (fst_q)
        CMD:     fst_d = DHI;
        DHI:     fst_d = DLO;
        DLO:     fst_d = CMD;
        default: fst_d = CMD;
      endcase
    end
  end

  // Frame FSM outputs: which register takes the incoming byte
  always_comb begin
    cap_cmd  = byte_vld && fst_q == CMD;
    cap_hi   = byte_vld && fst_q == DHI;
    complete = byte_vld && fst_q == DLO;
  end

  // Output next-state: completion beats a same-clk clear
  always_comb begin
    cmd_d  = cmd_q;
    data_d = data_q;
    rdy_d  = rdy_q;
    ovr_d  = 1'b0;
    if (complete) begin
      cmd_d  = cmd_sh_q;
      data_d = {dhi_sh_q, rx_byte};
      rdy_d  = 1'b1;
      ovr_d  = rdy_q & ~clr_cmd_rdy;
    end else if (clr_cmd_rdy) begin
      rdy_d = 1'b0;
    end
  end

  // Shadow and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_sh_q <= 8'h00;
      dhi_sh_q <= 8'h00;
      cmd_q    <= 8'h00;
      data_q   <= 16'h0000;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (cap_cmd) cmd_sh_q <= rx_byte;
      if (cap_hi)  dhi_sh_q <= rx_byte;
      cmd_q  <= cmd_d;
      data_q <= data_d;
      rdy_q  <= rdy_d;
      ovr_q  <= ovr_d;
    end
  end

  assign cmd     = cmd_q;
  assign data    = data_q;
  assign cmd_rdy = rdy_q;
  assign ovr_err = ovr_q;

endmodule

// File: tb/tb_cmd_frame_rcvr.sv
// Directed bench for cmd_frame_rcvr (fast instance BAUD_DIV=16,
// TIMEOUT_CLKS=1000, plus a default-parameter instance for reset values).
module tb_cmd_frame_rcvr;

  localparam int BD = 16;
  localparam int TO = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy, frm_err, ovr_err;

  logic        rx_def = 1'b1;
  logic        clr_def = 1'b0;
  logic [7:0]  d_cmd;
  logic [15:0] d_data;
  logic        d_rdy, d_frm, d_ovr;

  cmd_frame_rcvr #(.BAUD_DIV(BD), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  cmd_frame_rcvr dut_def (
    .clk(clk), .rst(rst), .RX(rx_def), .clr_cmd_rdy(clr_def),
    .cmd(d_cmd), .data(d_data), .cmd_rdy(d_rdy), .frm_err(d_frm), .ovr_err(d_ovr)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- event monitor (sampled mid-cycle) ----------------
  int   cyc = 0, vld_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
  int   last_vld_cyc = 0, rdy_rise_cyc = 0;
  logic rdy_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dut.u_rx.byte_vld_o === 1'b1) begin
      vld_cnt = vld_cnt + 1;
      last_vld_cyc = cyc;
    end
    if (frm_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (ovr_err === 1'b1) ovr_cnt = ovr_cnt + 1;
    if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) rdy_rise_cyc = cyc;
    rdy_prev = cmd_rdy;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_bit;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send_byte(c, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (cmd !== 8'h00)      begin n_err++; $display("FAIL rst_cmd got %h want 00", cmd); end
    n_vec++; if (data !== 16'h0000)  begin n_err++; $display("FAIL rst_data got %h want 0000", data); end
    n_vec++; if (cmd_rdy !== 1'b0)   begin n_err++; $display("FAIL rst_rdy got %b want 0", cmd_rdy); end
    n_vec++; if (frm_err !== 1'b0 || ovr_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b%b want 00", frm_err, ovr_err); end
    n_vec++; if ({d_cmd, d_data, d_rdy, d_frm, d_ovr} !== 27'd0) begin n_err++; $display("FAIL rst_def got %h want 0", {d_cmd, d_data, d_rdy, d_frm, d_ovr}); end
    rst = 1'b0;
    idle(3 * BD);
    n_vec++; if (vld_cnt !== 0 || ferr_cnt !== 0) begin n_err++; $display("FAIL rst_release got vld=%0d ferr=%0d want 0/0", vld_cnt, ferr_cnt); end
  endtask

  task automatic test_basic_frame();
    int v0;
    v0 = vld_cnt;
    send_frame(8'h02, 8'h0E, 8'hAD);
    idle(2);
    n_vec++; if (cmd !== 8'h02)      begin n_err++; $display("FAIL basic_cmd got %h want 02", cmd); end
    n_vec++; if (data !== 16'h0EAD)  begin n_err++; $display("FAIL basic_data got %h want 0EAD", data); end
    n_vec++; if (cmd_rdy !== 1'b1)   begin n_err++; $display("FAIL basic_rdy got %b want 1", cmd_rdy); end
    n_vec++; if (vld_cnt - v0 !== 3) begin n_err++; $display("FAIL basic_bytes got %0d want 3", vld_cnt - v0); end
    n_vec++; if (rdy_rise_cyc - last_vld_cyc !== 1) begin n_err++; $display("FAIL basic_latency got %0d want 1", rdy_rise_cyc - last_vld_cyc); end
  endtask

  task automatic test_clear();
    pulse_clr();
    n_vec++; if (cmd_rdy !== 1'b0)  begin n_err++; $display("FAIL clr_rdy got %b want 0", cmd_rdy); end
    idle(5);
    n_vec++; if (cmd !== 8'h02 || data !== 16'h0EAD) begin n_err++; $display("FAIL clr_hold got %h/%h want 02/0EAD", cmd, data); end
  endtask

  task automatic test_overrun();
    int o0;
    int k;
    bit hit;
    send_frame(8'h11, 8'h22, 8'h33);
    o0 = ovr_cnt;
    send_frame(8'h05, 8'h12, 8'h34);
    idle(2);
    n_vec++; if (cmd !== 8'h05 || data !== 16'h1234) begin n_err++; $display("FAIL ovr_data got %h/%h want 05/1234", cmd, data); end
    n_vec++; if (ovr_cnt - o0 !== 1) begin n_err++; $display("FAIL ovr_pulse got %0d cycles want 1", ovr_cnt - o0); end
    n_vec++; if (cmd_rdy !== 1'b1)   begin n_err++; $display("FAIL ovr_rdy got %b want 1", cmd_rdy); end
    // clear coinciding with completion: completion wins, no overrun
    o0 = ovr_cnt;
    hit = 1'b0;
    fork
      send_frame(8'h09, 8'h87, 8'h65);
      begin
        k = 0;
        for (int t = 0; t < 2000 && !hit; t++) begin
          @(negedge clk);
          if (dut.u_rx.byte_vld_o === 1'b1) begin
            k++;
            if (k == 3) begin
              clr_cmd_rdy = 1'b1;
              @(negedge clk);
              clr_cmd_rdy = 1'b0;
              hit = 1'b1;
            end
          end
        end
      end
    join
    idle(2);
    n_vec++; if (!hit)                begin n_err++; $display("FAIL ovr_clr_wait got timeout want 3rd byte"); end
    n_vec++; if (cmd_rdy !== 1'b1)    begin n_err++; $display("FAIL ovr_clr_rdy got %b want 1", cmd_rdy); end
    n_vec++; if (ovr_cnt - o0 !== 0)  begin n_err++; $display("FAIL ovr_clr_pulse got %0d want 0", ovr_cnt - o0); end
    n_vec++; if (cmd !== 8'h09 || data !== 16'h8765) begin n_err++; $display("FAIL ovr_clr_data got %h/%h want 09/8765", cmd, data); end
  endtask

  task automatic test_frame_error();
    int f0;
    pulse_clr();
    f0 = ferr_cnt;
    send_byte(8'h03, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(3 * BD);
    n_vec++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - f0); end
    send_frame(8'h06, 8'hAB, 8'hCD);
    idle(2);
    n_vec++; if (cmd !== 8'h06 || data !== 16'hABCD) begin n_err++; $display("FAIL ferr_data got %h/%h want 06/ABCD", cmd, data); end
    n_vec++; if (cmd_rdy !== 1'b1)    begin n_err++; $display("FAIL ferr_rdy got %b want 1", cmd_rdy); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    pulse_clr();
    v0 = vld_cnt;
    f0 = ferr_cnt;
    RX = 1'b0;
    repeat (BD / 4) @(negedge clk);
    idle(3 * BD);
    n_vec++; if (vld_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_evt got vld=%0d ferr=%0d want 0/0", vld_cnt - v0, ferr_cnt - f0); end
    send_frame(8'h0A, 8'h0B, 8'h0C);
    idle(2);
    n_vec++; if (cmd !== 8'h0A || data !== 16'h0B0C || cmd_rdy !== 1'b1) begin n_err++; $display("FAIL glitch_frame got %h/%h/%b want 0A/0B0C/1", cmd, data, cmd_rdy); end
  endtask

  task automatic test_timeout();
    pulse_clr();
    send_byte(8'h01, 1'b1);
    idle(1200);
    n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL to_gap_rdy got %b want 0", cmd_rdy); end
    send_frame(8'h07, 8'h00, 8'h10);
    idle(2);
`ifdef FRAME_TIMEOUT_EN
    n_vec++; if (cmd !== 8'h07 || data !== 16'h0010) begin n_err++; $display("FAIL to_data got %h/%h want 07/0010", cmd, data); end
`else
    n_vec++; if (cmd !== 8'h01 || data !== 16'h0700) begin n_err++; $display("FAIL to_data got %h/%h want 01/0700", cmd, data); end
`endif
    n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL to_rdy got %b want 1", cmd_rdy); end
    // leave the frame FSM aligned for the next test
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(BD);
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h33, 8'h44, 8'h55);
    n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rmid_pre got %b want 1", cmd_rdy); end
    send_byte(8'h02, 1'b1);
    RX = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (cmd !== 8'h00 || data !== 16'h0000 || cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rmid_out got %h/%h/%b want 00/0000/0", cmd, data, cmd_rdy); end
    rst = 1'b0;
    idle(3 * BD);
    send_frame(8'h02, 8'h0E, 8'hAD);
    idle(2);
    n_vec++; if (cmd !== 8'h02 || data !== 16'h0EAD || cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rmid_frame got %h/%h/%b want 02/0EAD/1", cmd, data, cmd_rdy); end
    n_vec++; if ({d_cmd, d_data, d_rdy} !== 25'd0) begin n_err++; $display("FAIL def_idle got %h want 0", {d_cmd, d_data, d_rdy}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_clear();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_timeout();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
